// File: rtl/keypad_scanner.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// keypad_scanner : 4x4 active-low matrix keypad scanner with debounce and
//                  a four-digit hex entry register.          Revision: 1.0
// ============================================================================
module keypad_scanner #(
  parameter int SCAN_TICK      = 100000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  row_n,
  input  logic        clear,
  output logic [3:0]  col_n,
  output logic [3:0]  key_code,
  output logic        key_valid,
  output logic        key_held,
  output logic [15:0] entry_value,
  output logic [2:0]  entry_count
);

  localparam int                 c_DIV_W    = $clog2(SCAN_TICK);
  localparam int                 c_CNT_W    = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(SCAN_TICK - 1);
  localparam logic [c_CNT_W-1:0] c_DEB      = c_CNT_W'(DEBOUNCE_SCANS);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CONFIRM = 2'd1,
    S_HELD    = 2'd2,
    S_RELEASE = 2'd3
  } state_t;

  logic [3:0]         r_row_s1, r_row_s2;
  logic [c_DIV_W-1:0] r_div;
  logic [1:0]         r_col_idx;
  logic [3:0]         r_col_n;
  logic [3:0][3:0]    r_samp;
  state_t             r_state;
  logic [c_CNT_W-1:0] r_cnt;
  logic [3:0]         r_cand;
  logic [3:0]         r_key_code;
  logic               r_key_valid;
  logic               r_key_held;
  logic [15:0]        r_entry;
  logic [2:0]         r_count;

  logic               w_tick, w_eval, w_none, w_one, w_accept;
  logic [4:0]         w_nhits;
  logic [3:0]         w_key;
  logic [c_CNT_W-1:0] w_cnt_inc;

  function automatic logic [3:0] key_map(input logic [3:0] idx);
    logic [3:0] code;
    case (idx)  // idx = {row, col}
      4'd0:  code = 4'h1;  4'd1:  code = 4'h2;  4'd2:  code = 4'h3;  4'd3:  code = 4'hA;
      4'd4:  code = 4'h4;  4'd5:  code = 4'h5;  4'd6:  code = 4'h6;  4'd7:  code = 4'hB;
      4'd8:  code = 4'h7;  4'd9:  code = 4'h8;  4'd10: code = 4'h9;  4'd11: code = 4'hC;
      4'd12: code = 4'h0;  4'd13: code = 4'hF;  4'd14: code = 4'hE;  default: code = 4'hD;
    endcase
    return code;
  endfunction

  assign w_tick = (r_div == c_DIV_LAST);
  assign w_eval = w_tick && (r_col_idx == 2'd3);

  // Column 3 is still being sampled on the evaluation tick, so use it live.
  always_comb begin
    logic [3:0] col_hits;
    w_nhits = 5'd0;
    w_key   = 4'h0;
    for (int c = 0; c < 4; c++) begin
      col_hits = (c == 3) ? ~r_row_s2 : r_samp[c];
      for (int r = 0; r < 4; r++) begin
        if (col_hits[r]) begin
          w_nhits = w_nhits + 5'd1;
          w_key   = key_map(4'(r * 4 + c));
        end
      end
    end
  end

  assign w_none    = (w_nhits == 5'd0);
  assign w_one     = (w_nhits == 5'd1);
  assign w_cnt_inc = r_cnt + c_CNT_ONE;
  assign w_accept  = w_eval && (r_state == S_CONFIRM) && w_one &&
                     (w_key == r_cand) && (w_cnt_inc == c_DEB);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_row_s1  <= 4'hF;
      r_row_s2  <= 4'hF;
      r_div     <= '0;
      r_col_idx <= 2'd0;
      r_col_n   <= 4'b1110;
      r_samp    <= '0;
    end else begin
      r_row_s1 <= row_n;
      r_row_s2 <= r_row_s1;
      if (w_tick) begin
        r_div             <= '0;
        r_samp[r_col_idx] <= ~r_row_s2;
        r_col_idx         <= r_col_idx + 2'd1;
        r_col_n           <= ~(4'b0001 << (r_col_idx + 2'd1));
      end else begin
        r_div <= r_div + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_cand      <= 4'h0;
      r_key_code  <= 4'h0;
      r_key_valid <= 1'b0;
      r_key_held  <= 1'b0;
      r_entry     <= 16'h0000;
      r_count     <= 3'd0;
    end else begin
      r_key_valid <= 1'b0;
      if (w_eval) begin
        case (r_state)
          S_IDLE: begin
            if (w_one) begin
              r_state <= S_CONFIRM;
              r_cand  <= w_key;
              r_cnt   <= c_CNT_ONE;
            end
          end
          S_CONFIRM: begin
            if (w_one && (w_key == r_cand)) begin
              if (w_cnt_inc == c_DEB) begin
                r_state     <= S_HELD;
                r_key_code  <= r_cand;
                r_key_valid <= 1'b1;
                r_key_held  <= 1'b1;
              end else begin
                r_cnt <= w_cnt_inc;
              end
            end else begin
              r_state <= S_IDLE;
            end
          end
          S_HELD: begin
            if (w_none) begin
              r_state <= S_RELEASE;
              r_cnt   <= c_CNT_ONE;
            end
          end
          default: begin
            if (!w_none) begin
              r_state <= S_HELD;
            end else if (w_cnt_inc == c_DEB) begin
              r_state    <= S_IDLE;
              r_key_held <= 1'b0;
              r_cnt      <= '0;
            end else begin
              r_cnt <= w_cnt_inc;
            end
          end
        endcase
      end

      // Clear has priority: a key accepted in the same cycle is not recorded.
      if (clear) begin
        r_entry <= 16'h0000;
        r_count <= 3'd0;
      end else if (w_accept) begin
        r_entry <= {r_entry[11:0], r_cand};
        if (r_count != 3'd4) r_count <= r_count + 3'd1;
      end
    end
  end

  assign col_n       = r_col_n;
  assign key_code    = r_key_code;
  assign key_valid   = r_key_valid;
  assign key_held    = r_key_held;
  assign entry_value = r_entry;
  assign entry_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_keypad_scanner.sv
`timescale 1ns/1ps
`default_nettype none
// Scoreboard bench for keypad_scanner: stimulus queues expected key events,
// a negedge monitor checks every key_valid pulse against the queue.
module tb_keypad_scanner;

  localparam int ST    = 8;
  localparam int DEB   = 3;
  localparam int FRAME = 4 * ST;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        clear = 1'b0;
  logic [3:0]  row_n;
  logic [3:0]  col_n;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_held;
  logic [15:0] entry_value;
  logic [2:0]  entry_count;
  logic [15:0] pressed = 16'h0000;  // bit row*4+col

  typedef struct {
    logic [3:0]  code;
    logic [15:0] entry;
    logic [2:0]  count;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int          n_pulses = 0;
  int          cyc = 0;
  int          pulse_cyc = 0;
  logic [15:0] m_entry = 16'h0000;
  logic [2:0]  m_count = 3'd0;

  keypad_scanner #(.SCAN_TICK(ST), .DEBOUNCE_SCANS(DEB)) dut (
    .clk(clk), .reset(reset), .row_n(row_n), .clear(clear), .col_n(col_n),
    .key_code(key_code), .key_valid(key_valid), .key_held(key_held),
    .entry_value(entry_value), .entry_count(entry_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Keypad model: a pressed key pulls its row low while its column is driven.
  always_comb begin
    row_n = 4'hF;
    for (int r = 0; r < 4; r++)
      row_n[r] = ~|(pressed[r*4 +: 4] & ~col_n);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (reset && key_valid) begin
      n_pulses++;
      pulse_cyc = cyc;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse: key_code=%0h, expected no pulse", key_code);
      end else begin
        e = sb.pop_front();
        chk("pulse_key_code", key_code, e.code);
        chk("pulse_entry_value", entry_value, e.entry);
        chk("pulse_entry_count", entry_count, e.count);
      end
    end
  end

  task automatic expect_key(input logic [3:0] code);
    m_entry = {m_entry[11:0], code};
    if (m_count < 3'd4) m_count = m_count + 3'd1;
    sb.push_back('{code, m_entry, m_count});
  endtask

  task automatic wait_pulses(input int target, input string name);
    int i = 0;
    while (n_pulses < target && i < 6 * FRAME) begin
      @(negedge clk);
      i++;
    end
    #1;
    chk({name, "_pulse_seen"}, 32'(n_pulses >= target), 1);
  endtask

  task automatic accept_key(input int idx, input logic [3:0] code, input string name);
    int t;
    int base;
    base = n_pulses;
    expect_key(code);
    @(negedge clk);
    pressed = 16'h0000;
    pressed[idx] = 1'b1;
    t = cyc;
    wait_pulses(base + 1, name);
    chk({name, "_latency"}, 32'((pulse_cyc - t >= (DEB - 1) * FRAME) &&
                                (pulse_cyc - t <= (DEB + 1) * FRAME + 3)), 1);
    @(negedge clk);
    chk({name, "_held"}, 32'(key_held), 1);
  endtask

  task automatic release_all(input string name);
    int t;
    int i = 0;
    pressed = 16'h0000;
    t = cyc;
    while (key_held && i < 6 * FRAME) begin
      @(negedge clk);
      i++;
    end
    chk({name, "_release"}, 32'(!key_held && (cyc - t >= (DEB - 1) * FRAME) &&
                                (cyc - t <= (DEB + 1) * FRAME + 3)), 1);
    repeat (FRAME) @(negedge clk);
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int base;
    int t;
    // 1. Reset mid-scan, then column rotation
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (13) @(negedge clk);
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk("rst_col_n", col_n, 4'b1110);
    chk("rst_key_valid", key_valid, 0);
    chk("rst_key_held", key_held, 0);
    chk("rst_entry_value", entry_value, 16'h0000);
    chk("rst_entry_count", entry_count, 0);
    @(negedge clk);
    reset = 1'b1;
    repeat (4) @(negedge clk);
    chk("col_phase0", col_n, 4'b1110);
    repeat (8) @(negedge clk);
    chk("col_phase1", col_n, 4'b1101);
    repeat (8) @(negedge clk);
    chk("col_phase2", col_n, 4'b1011);
    repeat (8) @(negedge clk);
    chk("col_phase3", col_n, 4'b0111);
    repeat (8) @(negedge clk);
    chk("col_wrap", col_n, 4'b1110);

    // 2. Stable press of key 5 (row1/col1)
    accept_key(5, 4'h5, "t2_key5");
    repeat (3 * FRAME) @(negedge clk);
    chk("t2_single_pulse", n_pulses, 1);
    release_all("t2");

    // 3. Bouncing key 9 (row2/col2)
    base = n_pulses;
    for (int k = 0; k < 2; k++) begin
      pressed[10] = 1'b1;
      repeat (FRAME) @(negedge clk);
      pressed = 16'h0000;
      repeat (FRAME) @(negedge clk);
    end
    chk("t3_no_bounce_pulse", n_pulses, base);
    accept_key(10, 4'h9, "t3_key9");
    release_all("t3");

    // 4. Multi-key, hold-over and short release gap
    base = n_pulses;
    pressed = 16'h0003;
    repeat (6 * FRAME) @(negedge clk);
    chk("t4_multi_no_pulse", n_pulses, base);
    pressed = 16'h0000;
    repeat (2 * FRAME) @(negedge clk);
    accept_key(2, 4'h3, "t4_key3");
    pressed[4] = 1'b1;
    repeat (3 * FRAME) @(negedge clk);
    pressed = 16'h0000;
    repeat (FRAME) @(negedge clk);
    pressed[2] = 1'b1;
    repeat (4 * FRAME) @(negedge clk);
    chk("t4_still_held", key_held, 1);
    chk("t4_no_new_pulse", n_pulses, base + 1);
    release_all("t4");

    // 5. Entry register and clear priority
    accept_key(0, 4'h1, "t5_key1");  release_all("t5a");
    accept_key(1, 4'h2, "t5_key2");  release_all("t5b");
    accept_key(2, 4'h3, "t5_key3");  release_all("t5c");
    accept_key(3, 4'hA, "t5_keyA");  release_all("t5d");
    accept_key(7, 4'hB, "t5_keyB");  release_all("t5e");
    chk("t5_entry_value", entry_value, 16'h23AB);
    chk("t5_entry_count", entry_count, 4);
    base = n_pulses;
    @(negedge clk);
    clear = 1'b1;
    m_entry = 16'h0000;
    m_count = 3'd0;
    sb.push_back('{4'hC, 16'h0000, 3'd0});
    pressed[11] = 1'b1;
    wait_pulses(base + 1, "t5_keyC");
    @(negedge clk);
    clear = 1'b0;
    @(negedge clk);
    chk("t5_clear_key_code", key_code, 4'hC);
    chk("t5_clear_entry", entry_value, 16'h0000);
    chk("t5_clear_count", entry_count, 0);
    release_all("t5f");

    // 6. Reset while key 7 (row2/col0) is held
    accept_key(8, 4'h7, "t6_key7");
    repeat (FRAME + 5) @(negedge clk);
    @(posedge clk);
    #3 reset = 1'b0;
    #1;
    chk("t6_rst_held", key_held, 0);
    chk("t6_rst_entry", entry_value, 16'h0000);
    chk("t6_rst_col_n", col_n, 4'b1110);
    m_entry = 16'h0000;
    m_count = 3'd0;
    expect_key(4'h7);
    base = n_pulses;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    t = cyc;
    wait_pulses(base + 1, "t6_repress");
    chk("t6_latency", 32'((pulse_cyc - t >= (DEB - 1) * FRAME) &&
                          (pulse_cyc - t <= (DEB + 1) * FRAME + 3)), 1);
    release_all("t6");

    chk("scoreboard_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
